quad_decoder_array: RTL
=======================

# quad_decoder_array

Multi-channel quadrature encoder decoder: the parametrised successor to the single-channel 24-bit encoder counter. Each channel synchronises its A/B pins, rejects glitches with a stability filter, and maintains a wrapping signed position count with per-channel clear and direction invert. It also flags illegal double-bit transitions with a sticky error bit and reports per-window step velocity. It sits between the board encoder pins and the Qsys-facing register logic.

## Interface
- NUM_CH, 2, number of independent encoder channels (>=1)
- COUNTBITS, 24, position counter width per channel
- FILTER_LEN, 4, consecutive stable cycles required to accept a new A/B state (>=1)
- VEL_WINDOW, 50000, velocity sample window in clock cycles (>=2)
- VELBITS, 16, signed velocity width per channel

- CLOCK_50  in  1  sole clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- A  in  NUM_CH  encoder phase A per channel, asynchronous
- B  in  NUM_CH  encoder phase B per channel, asynchronous
- dir_inv  in  NUM_CH  1 = negate step direction for that channel, quasi-static
- clr  in  NUM_CH  synchronous clear of that channel's position count
- err_clr  in  NUM_CH  clears that channel's sticky error bit
- c_out  out  NUM_CH*COUNTBITS  position counts, channel i at [i*COUNTBITS +: COUNTBITS]
- vel_out  out  NUM_CH*VELBITS  signed steps per last window, channel i at [i*VELBITS +: VELBITS]
- vel_valid  out  1  one-cycle pulse when vel_out updates
- err_flag  out  NUM_CH  sticky illegal-transition flag

## Operation
- Synchroniser: per channel, {A,B} through two flops -> candidate state cand[1:0].
- Filter: register f[1:0] holds accepted state. Stability counter resets whenever cand changes or equals f; f <= cand once cand has differed from f and held constant for FILTER_LEN consecutive cycles. f_prev registers f.
- Decode from f_prev -> f ({A,B}): forward (+1) sequence 00->10->11->01->00; reverse is the inverse sequence; no change = 0. dir_inv flips sign.
- Illegal: f_prev and f differ in both bits -> step 0, err_flag set.
- Count: count <= count + step, modulo 2^COUNTBITS (two's complement wrap both ways). clr wins over a simultaneous step (result 0).
- err_flag: set on illegal transition; cleared by err_clr; set wins if both same cycle.
- Velocity: shared window counter 0..VEL_WINDOW-1. Per-channel signed accumulator adds step each cycle, saturating at +(2^(VELBITS-1)-1) and -2^(VELBITS-1). In cycle with window counter = VEL_WINDOW-1: vel_out <= saturated(acc + step), acc <= 0, vel_valid <= 1 (high exactly the next cycle only). clr and dir_inv changes do not reset acc. Illegal transitions contribute 0.
- Channels fully independent except the shared window counter and vel_valid.

## Timing
- Reset (rst_n low at a rising edge): c_out = 0, vel_out = 0, vel_valid = 0, err_flag = 0, window counter = 0, acc = 0, stability counters = 0; f and f_prev load cand so no step is counted on reset release. Reset mid-operation discards in-progress filter qualification and partial window.
- Pin-to-count latency: pin change sampled at edge k -> cand at k+1 -> f at k+1+FILTER_LEN -> c_out at k+2+FILTER_LEN.
- Pulse shorter than FILTER_LEN cycles at cand: no f change, no count.
- clr/err_clr take effect on the edge they are sampled; c_out = 0 the following cycle.
- First vel_valid after reset: VEL_WINDOW cycles after reset release.
- Max step rate: one step per FILTER_LEN+1 cycles per channel; faster input is filtered, not miscounted as illegal unless f itself jumps both bits.

## Test plan
- Forward: ch0 drive 00->10->11->01->00 twice, each state held 10 cycles -> c_out ch0 = 8, ch1 = 0, err_flag = 0.
- Reverse wrap: from reset, ch1 one reverse step (00->01) -> ch1 count = 0xFFFFFF; dir_inv[1]=1 then same step -> back to 0.
- Glitch: ch0 at 00, pulse A high for FILTER_LEN-1 = 3 cycles -> count unchanged; hold 4+ cycles -> count +1 exactly at k+6.
- Illegal: ch0 00->11 held 10 cycles -> err_flag[0]=1, count unchanged; err_clr[0] with simultaneous new illegal -> flag stays 1; err_clr alone -> 0.
- Velocity: VEL_WINDOW=100, 5 forward steps ch0 and 3 reverse ch1 within window -> vel_valid pulse at cycle 100, vel_out ch0 = +5, ch1 = -3; next empty window -> 0; VELBITS=4 with 9 steps -> saturates +7.
- Clear/reset: clr[0] same cycle as a forward step -> count 0; rst_n low mid-window with A/B at 11 -> all outputs 0, no step on release.

Source files
------------

// File: rtl/quad_decoder_array.sv
// Multi-channel quadrature decoder: sync, glitch filter, wrapping position count,
// sticky illegal-transition flag and per-window saturating step velocity.
module quad_decoder_array #(
   parameter int NUM_CH     = 2,
   parameter int COUNTBITS  = 24,
   parameter int FILTER_LEN = 4,
   parameter int VEL_WINDOW = 50000,
   parameter int VELBITS    = 16
) (
   input  logic                           CLOCK_50,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              A,
   input  logic [NUM_CH-1:0]              B,
   input  logic [NUM_CH-1:0]              dir_inv,
   input  logic [NUM_CH-1:0]              clr,
   input  logic [NUM_CH-1:0]              err_clr,
   output logic [NUM_CH*COUNTBITS-1:0]    c_out,
   output logic [NUM_CH*VELBITS-1:0]      vel_out,
   output logic                           vel_valid,
   output logic [NUM_CH-1:0]              err_flag
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(VEL_WINDOW);

   logic [NUM_CH-1:0][1:0]           sync1, cand, cand_d, f, f_prev;
   logic [NUM_CH-1:0][CW-1:0]        stab, stab_inc;
   logic [NUM_CH-1:0][COUNTBITS-1:0] count;
   logic [NUM_CH-1:0][VELBITS-1:0]   acc, acc_next, vel;
   logic [NUM_CH-1:0][VELBITS:0]     vsum;
   logic [NUM_CH-1:0]                fwd, rev, up, dn, illegal;
   logic [WW-1:0]                    win;
   logic                             win_end;

   // Synchroniser keeps sampling through reset so f can load a settled cand.
   always_ff @(posedge CLOCK_50) begin
      for (int i = 0; i < NUM_CH; i++) begin
         sync1[i] <= {A[i], B[i]};
      end
      cand <= sync1;
   end

   assign win_end = (win == WW'(VEL_WINDOW - 1));

   always_comb begin
      fwd      = '0;
      rev      = '0;
      up       = '0;
      dn       = '0;
      illegal  = '0;
      vsum     = '0;
      acc_next = '0;
      stab_inc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // stab_inc counts cycles cand has held its current value, this one included
         stab_inc[i] = (cand[i] != cand_d[i]) ? CW'(1) : stab[i] + CW'(1);
         case ({f_prev[i], f[i]})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd[i] = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: rev[i] = 1'b1;
            default: ;
         endcase
         illegal[i] = ((f_prev[i] ^ f[i]) == 2'b11);
         up[i] = dir_inv[i] ? rev[i] : fwd[i];
         dn[i] = dir_inv[i] ? fwd[i] : rev[i];
         vsum[i] = {acc[i][VELBITS-1], acc[i]} + {{VELBITS{dn[i]}}, up[i] | dn[i]};
         if (vsum[i][VELBITS] != vsum[i][VELBITS-1]) begin
            acc_next[i] = vsum[i][VELBITS] ? {1'b1, {(VELBITS-1){1'b0}}}
                                           : {1'b0, {(VELBITS-1){1'b1}}};
         end else begin
            acc_next[i] = vsum[i][VELBITS-1:0];
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         f         <= cand;
         f_prev    <= cand;
         cand_d    <= cand;
         stab      <= '0;
         count     <= '0;
         acc       <= '0;
         vel       <= '0;
         win       <= '0;
         vel_valid <= 1'b0;
         err_flag  <= '0;
      end else begin
         cand_d    <= cand;
         f_prev    <= f;
         vel_valid <= win_end;
         win       <= win_end ? '0 : win + 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (cand[i] == f[i]) begin
               stab[i] <= '0;
            end else if (stab_inc[i] >= CW'(FILTER_LEN)) begin
               f[i]    <= cand[i];
               stab[i] <= '0;
            end else begin
               stab[i] <= stab_inc[i];
            end

            if (clr[i]) begin
               count[i] <= '0;
            end else begin
               count[i] <= count[i] + {{(COUNTBITS-1){dn[i]}}, up[i] | dn[i]};
            end

            if (illegal[i]) begin
               err_flag[i] <= 1'b1;
            end else if (err_clr[i]) begin
               err_flag[i] <= 1'b0;
            end

            if (win_end) begin
               vel[i] <= acc_next[i];
               acc[i] <= '0;
            end else begin
               acc[i] <= acc_next[i];
            end
         end
      end
   end

   assign c_out   = count;
   assign vel_out = vel;

endmodule
